// File: rtl/axis_pkt_fifo.sv
// First-word-fall-through stream FIFO with byte keep, registered ready/almost-full
// and an optional store-and-forward mode that holds output until a full packet is stored.
module axis_pkt_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 16,
  parameter bit PKT_MODE  = 1'b0,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [DATA_W/8-1:0]      s_keep,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [DATA_W-1:0]        m_data,
  output logic [DATA_W/8-1:0]      m_keep,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     s_afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = DATA_W / 8;
  localparam int EW = DATA_W + KW + 1;

  typedef enum logic [1:0] {HOLD, FWD, RELEASE} state_t;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, pkt_count_q;
  logic              s_ready_q, s_afull_q;
  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [KW-1:0]     out_keep_q;
  state_t            state_q;

  logic              wr_en, rd_en, last_rd, load, load_ok;
  logic [CW-1:0]     mem_cnt, pkt_rem, count_d, pkt_count_d;
  state_t            state_d;

  always_comb begin
    wr_en       = s_valid && s_ready_q;
    rd_en       = out_valid_q && m_ready;
    last_rd     = rd_en && out_last_q;
    // The output register is counted in count_q, so the RAM holds count minus that beat.
    mem_cnt     = count_q - CW'(out_valid_q);
    pkt_rem     = pkt_count_q - CW'(last_rd);
    count_d     = count_q + CW'(wr_en) - CW'(rd_en);
    pkt_count_d = pkt_count_q + CW'(wr_en && s_last) - CW'(last_rd);
    // Store-and-forward only pulls a beat out of RAM if its packet is already complete.
    load_ok     = !PKT_MODE || (state_q == RELEASE && !last_rd) || (pkt_rem != '0);
    load        = (mem_cnt != '0) && (!out_valid_q || rd_en) && load_ok;

    state_d = state_q;
    case (state_q)
      HOLD: begin
        if (pkt_count_q != '0)
          state_d = FWD;
        else if (count_q == CW'(DEPTH))
          state_d = RELEASE;
      end
      FWD: begin
        if (last_rd && pkt_count_d == '0)
          state_d = HOLD;
      end
      RELEASE: begin
        if (last_rd)
          state_d = (pkt_rem != '0) ? FWD : HOLD;
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= {s_last, s_keep, s_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      s_ready_q   <= 1'b0;
      s_afull_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      state_q     <= HOLD;
    end else begin
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      s_ready_q   <= (count_d < CW'(DEPTH));
      s_afull_q   <= (count_d >= CW'(AFULL_LVL));
      state_q     <= state_d;
      if (wr_en)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) begin
        {out_last_q, out_keep_q, out_data_q} <= mem_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        out_valid_q <= 1'b1;
      end else if (rd_en) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign s_ready   = s_ready_q;
  assign s_afull   = s_afull_q;
  assign m_valid   = out_valid_q;
  assign m_last    = out_last_q;
  assign m_data    = out_data_q;
  assign m_keep    = out_keep_q;
  assign count     = count_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench: one cut-through and one store-and-forward instance, DEPTH=16, DATA_W=64.
module tb_axis_pkt_fifo;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          c_s_valid, c_s_ready, c_s_last, c_m_valid, c_m_ready, c_m_last, c_s_afull;
  logic [DW-1:0] c_s_data, c_m_data;
  logic [KW-1:0] c_s_keep, c_m_keep;
  logic [CW-1:0] c_count, c_pkt_count;

  logic          p_s_valid, p_s_ready, p_s_last, p_m_valid, p_m_ready, p_m_last, p_s_afull;
  logic [DW-1:0] p_s_data, p_m_data;
  logic [KW-1:0] p_s_keep, p_m_keep;
  logic [CW-1:0] p_count, p_pkt_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(16), .PKT_MODE(1'b0)) u_ct (
    .clk(clk), .rst_n(rst_n),
    .s_valid(c_s_valid), .s_ready(c_s_ready), .s_last(c_s_last), .s_data(c_s_data), .s_keep(c_s_keep),
    .m_valid(c_m_valid), .m_ready(c_m_ready), .m_last(c_m_last), .m_data(c_m_data), .m_keep(c_m_keep),
    .count(c_count), .pkt_count(c_pkt_count), .s_afull(c_s_afull)
  );

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(16), .PKT_MODE(1'b1)) u_sf (
    .clk(clk), .rst_n(rst_n),
    .s_valid(p_s_valid), .s_ready(p_s_ready), .s_last(p_s_last), .s_data(p_s_data), .s_keep(p_s_keep),
    .m_valid(p_m_valid), .m_ready(p_m_ready), .m_last(p_m_last), .m_data(p_m_data), .m_keep(p_m_keep),
    .count(p_count), .pkt_count(p_pkt_count), .s_afull(p_s_afull)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_s_valid = 0; c_s_last = 0; c_s_data = '0; c_s_keep = '0; c_m_ready = 0;
    p_s_valid = 0; p_s_last = 0; p_s_data = '0; p_s_keep = '0; p_m_ready = 0;
    tick(); tick();
    total_cnt++;
    if ({c_s_ready, c_m_valid, c_m_last, c_s_afull, c_count, c_pkt_count} !== 14'd0)
      $display("FAIL reset_ct_flags actual=%b required=0", {c_s_ready, c_m_valid, c_m_last, c_s_afull, c_count, c_pkt_count});
    else pass_cnt++;
    total_cnt++;
    if ({c_m_data, c_m_keep} !== 72'd0)
      $display("FAIL reset_ct_data actual=%h required=0", {c_m_data, c_m_keep});
    else pass_cnt++;
    total_cnt++;
    if ({p_s_ready, p_m_valid, p_count, p_pkt_count} !== 12'd0)
      $display("FAIL reset_sf_flags actual=%b required=0", {p_s_ready, p_m_valid, p_count, p_pkt_count});
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({c_s_ready, p_s_ready} !== 2'b11)
      $display("FAIL reset_ready_after actual=%b required=11", {c_s_ready, p_s_ready});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    c_m_ready = 1; c_s_keep = 8'hFF;
    c_s_valid = 1; c_s_data = 64'h11; c_s_last = 0;
    tick();
    total_cnt++;
    if ({c_m_valid, c_count} !== {1'b0, 5'd1})
      $display("FAIL basic_e1 actual=%b/%0d required=0/1", c_m_valid, c_count);
    else pass_cnt++;
    c_s_data = 64'h22;
    tick();
    total_cnt++;
    if ({c_m_valid, c_m_last, c_m_data, c_count} !== {1'b1, 1'b0, 64'h11, 5'd2})
      $display("FAIL basic_e2 actual=%b/%b/%h/%0d required=1/0/11/2", c_m_valid, c_m_last, c_m_data, c_count);
    else pass_cnt++;
    c_s_data = 64'h33; c_s_last = 1;
    tick();
    total_cnt++;
    if ({c_m_valid, c_m_data, c_count, c_pkt_count} !== {1'b1, 64'h22, 5'd2, 5'd1})
      $display("FAIL basic_e3 actual=%b/%h/%0d/%0d required=1/22/2/1", c_m_valid, c_m_data, c_count, c_pkt_count);
    else pass_cnt++;
    c_s_valid = 0; c_s_last = 0;
    tick();
    total_cnt++;
    if ({c_m_valid, c_m_last, c_m_data, c_count} !== {1'b1, 1'b1, 64'h33, 5'd1})
      $display("FAIL basic_e4 actual=%b/%b/%h/%0d required=1/1/33/1", c_m_valid, c_m_last, c_m_data, c_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({c_m_valid, c_count, c_pkt_count} !== {1'b0, 5'd0, 5'd0})
      $display("FAIL basic_e5 actual=%b/%0d/%0d required=0/0/0", c_m_valid, c_count, c_pkt_count);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    int acc = 0;
    int rd = 0;
    logic w, r;
    c_m_ready = 0; c_s_keep = 8'hFF;
    for (int cyc = 0; cyc < 20; cyc++) begin
      c_s_valid = 1; c_s_data = 64'h100 + 64'(acc); c_s_last = (acc == 19);
      w = c_s_ready;
      tick();
      if (w) acc++;
      total_cnt++;
      if ({c_count, c_s_afull, c_s_ready} !== {5'(acc), acc >= 14, acc < 16})
        $display("FAIL fill_cyc%0d actual=%0d/%b/%b required=%0d/%b/%b", cyc, c_count, c_s_afull, c_s_ready, acc, acc >= 14, acc < 16);
      else pass_cnt++;
    end
    total_cnt++;
    if (acc != 16) $display("FAIL fill_accepted actual=%0d required=16", acc);
    else pass_cnt++;
    c_m_ready = 1;
    for (int cyc = 0; cyc < 80 && rd < 20; cyc++) begin
      c_s_valid = (acc < 20); c_s_data = 64'h100 + 64'(acc); c_s_last = (acc == 19);
      w = c_s_valid && c_s_ready;
      r = c_m_valid && c_m_ready;
      if (r) begin
        total_cnt++;
        if ({c_m_data, c_m_last} !== {64'h100 + 64'(rd), rd == 19})
          $display("FAIL fill_read%0d actual=%h/%b required=%h/%b", rd, c_m_data, c_m_last, 64'h100 + 64'(rd), rd == 19);
        else pass_cnt++;
        rd++;
      end
      tick();
      if (w) acc++;
      if (rd == 1 && r) begin
        total_cnt++;
        if ({c_s_ready, c_count} !== {1'b1, 5'd15})
          $display("FAIL fill_ready_rise actual=%b/%0d required=1/15", c_s_ready, c_count);
        else pass_cnt++;
      end
    end
    c_s_valid = 0; c_s_last = 0;
    total_cnt++;
    if ({5'(rd), c_count} !== {5'd20, 5'd0})
      $display("FAIL fill_drain actual=%0d/%0d required=20/0", rd, c_count);
    else pass_cnt++;
  endtask

  task automatic test_full_rw();
    logic [DW+KW-1:0] q[$];
    logic [DW+KW-1:0] exp_v;
    logic w, r;
    int acc = 0;
    c_m_ready = 0; c_s_last = 0;
    for (int cyc = 0; cyc < 24 && acc < 16; cyc++) begin
      c_s_valid = 1; c_s_data = {$urandom, $urandom}; c_s_keep = KW'($urandom);
      w = c_s_ready;
      tick();
      if (w) begin q.push_back({c_s_keep, c_s_data}); acc++; end
    end
    c_s_valid = 0;
    total_cnt++;
    if (c_count !== 5'd16) $display("FAIL fullrw_filled actual=%0d required=16", c_count);
    else pass_cnt++;
    c_m_ready = 1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      c_s_valid = 1; c_s_data = {$urandom, $urandom}; c_s_keep = KW'($urandom);
      w = c_s_ready;
      r = c_m_valid;
      if (r) begin
        exp_v = (q.size() > 0) ? q.pop_front() : '0;
        total_cnt++;
        if ({c_m_keep, c_m_data} !== exp_v)
          $display("FAIL fullrw_beat actual=%h required=%h", {c_m_keep, c_m_data}, exp_v);
        else pass_cnt++;
      end
      tick();
      if (w) q.push_back({c_s_keep, c_s_data});
      total_cnt++;
      if (c_count < 5'd15 || c_count > 5'd16)
        $display("FAIL fullrw_count actual=%0d required=15..16", c_count);
      else pass_cnt++;
    end
    c_s_valid = 0;
    for (int cyc = 0; cyc < 40 && c_m_valid; cyc++) begin
      exp_v = (q.size() > 0) ? q.pop_front() : '0;
      total_cnt++;
      if ({c_m_keep, c_m_data} !== exp_v)
        $display("FAIL fullrw_drain actual=%h required=%h", {c_m_keep, c_m_data}, exp_v);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({5'(q.size()), c_count} !== 10'd0)
      $display("FAIL fullrw_leftover actual=%0d/%0d required=0/0", q.size(), c_count);
    else pass_cnt++;
  endtask

  task automatic test_pkt_store();
    p_m_ready = 1; p_s_keep = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      p_s_valid = 1; p_s_data = 64'hB0 + 64'(i); p_s_last = (i == 3);
      tick();
      total_cnt++;
      if (p_m_valid !== 1'b0) $display("FAIL pkt_hold%0d actual=%b required=0", i, p_m_valid);
      else pass_cnt++;
    end
    p_s_valid = 0; p_s_last = 0;
    total_cnt++;
    if (p_pkt_count !== 5'd1) $display("FAIL pkt_count_one actual=%0d required=1", p_pkt_count);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if ({p_m_valid, p_m_last, p_m_data, p_m_keep} !== {1'b1, i == 3, 64'hB0 + 64'(i), 8'hF0})
        $display("FAIL pkt_out%0d actual=%b/%b/%h/%h required=1/%b/%h/f0", i, p_m_valid, p_m_last, p_m_data, p_m_keep, i == 3, 64'hB0 + 64'(i));
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({p_m_valid, p_pkt_count, p_count} !== 11'd0)
      $display("FAIL pkt_done actual=%b/%0d/%0d required=0/0/0", p_m_valid, p_pkt_count, p_count);
    else pass_cnt++;
  endtask

  task automatic test_release();
    int acc = 0;
    int rd = 0;
    logic w, r;
    p_m_ready = 1; p_s_keep = 8'hFF;
    for (int cyc = 0; cyc < 16; cyc++) begin
      p_s_valid = 1; p_s_data = 64'h200 + 64'(acc); p_s_last = 0;
      w = p_s_ready;
      tick();
      if (w) acc++;
    end
    total_cnt++;
    if ({p_count, p_s_ready, p_m_valid} !== {5'd16, 1'b0, 1'b0})
      $display("FAIL rel_full actual=%0d/%b/%b required=16/0/0", p_count, p_s_ready, p_m_valid);
    else pass_cnt++;
    p_s_data = 64'h200 + 64'(acc);
    tick();
    total_cnt++;
    if (p_m_valid !== 1'b0) $display("FAIL rel_enter actual=%b required=0", p_m_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({p_m_valid, p_m_data} !== {1'b1, 64'h200})
      $display("FAIL rel_first actual=%b/%h required=1/200", p_m_valid, p_m_data);
    else pass_cnt++;
    for (int cyc = 0; cyc < 80 && rd < 20; cyc++) begin
      p_s_valid = (acc < 20); p_s_data = 64'h200 + 64'(acc); p_s_last = (acc == 19);
      w = p_s_valid && p_s_ready;
      r = p_m_valid && p_m_ready;
      if (r) begin
        total_cnt++;
        if ({p_m_data, p_m_last} !== {64'h200 + 64'(rd), rd == 19})
          $display("FAIL rel_read%0d actual=%h/%b required=%h/%b", rd, p_m_data, p_m_last, 64'h200 + 64'(rd), rd == 19);
        else pass_cnt++;
        rd++;
      end
      tick();
      if (w) acc++;
    end
    p_s_valid = 0; p_s_last = 0;
    total_cnt++;
    if ({5'(rd), p_count, p_pkt_count} !== {5'd20, 5'd0, 5'd0})
      $display("FAIL rel_drain actual=%0d/%0d/%0d required=20/0/0", rd, p_count, p_pkt_count);
    else pass_cnt++;
    // Back in HOLD: an incomplete packet must stay invisible.
    for (int i = 0; i < 2; i++) begin
      p_s_valid = 1; p_s_data = 64'hC0 + 64'(i);
      tick();
    end
    p_s_valid = 0;
    tick(); tick(); tick();
    total_cnt++;
    if ({p_m_valid, p_count} !== {1'b0, 5'd2})
      $display("FAIL rel_hold_after actual=%b/%0d required=0/2", p_m_valid, p_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      p_s_valid = 1; p_s_data = 64'hD0 + 64'(i); p_s_last = 0;
      tick();
    end
    p_s_valid = 0;
    total_cnt++;
    if (p_count !== 5'd5) $display("FAIL mid_count5 actual=%0d required=5", p_count);
    else pass_cnt++;
    rst_n = 0;
    tick();
    total_cnt++;
    if ({p_count, p_pkt_count, p_m_valid, p_s_ready} !== 12'd0)
      $display("FAIL mid_reset actual=%0d/%0d/%b/%b required=0/0/0/0", p_count, p_pkt_count, p_m_valid, p_s_ready);
    else pass_cnt++;
    rst_n = 1;
    tick();
    p_s_keep = 8'h3C;
    p_s_valid = 1; p_s_data = 64'hA1; p_s_last = 0;
    tick();
    p_s_data = 64'hA2; p_s_last = 1;
    tick();
    p_s_valid = 0; p_s_last = 0;
    total_cnt++;
    if ({p_m_valid, p_pkt_count} !== {1'b0, 5'd1})
      $display("FAIL mid_pkt_stored actual=%b/%0d required=0/1", p_m_valid, p_pkt_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({p_m_valid, p_m_last, p_m_data, p_m_keep} !== {1'b1, 1'b0, 64'hA1, 8'h3C})
      $display("FAIL mid_beat0 actual=%b/%b/%h/%h required=1/0/a1/3c", p_m_valid, p_m_last, p_m_data, p_m_keep);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({p_m_valid, p_m_last, p_m_data} !== {1'b1, 1'b1, 64'hA2})
      $display("FAIL mid_beat1 actual=%b/%b/%h required=1/1/a2", p_m_valid, p_m_last, p_m_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({p_m_valid, p_count} !== 6'd0)
      $display("FAIL mid_empty actual=%b/%0d required=0/0", p_m_valid, p_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_pkt_store();
    test_release();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
